// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited memory requests, in-order response FIFO, redirect flush.
// Optional macro IF_MISALIGN_CHECK_EN: misaligned redirect sets sticky misalign and halts fetch.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        misalign
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDIT = (CW + 1)'(DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t          state, state_n;
    logic [31:0]     next_pc, next_pc_n;
    logic [CW-1:0]   out_cnt, out_n, drop_cnt, drop_n, occ, occ_n;
    logic [PW-1:0]   rd_ptr, rd_n, wr_ptr, wr_n;
    logic [31:0]     pc_mem  [DEPTH];
    logic [31:0]     ins_mem [DEPTH];
    logic            req_ok, req_ok_n;
    logic            req_fire, rsp_take, rsp_keep, pop, bad;
    logic [31:0]     tgt, pend, rsp_pc;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q;
    assign tgt      = redirect_pc;
    assign bad      = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign misalign = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_q <= 1'b0;
        else if (bad)
            misalign_q <= 1'b1;
    end
`else
    assign tgt      = redirect_pc & 32'hFFFF_FFFC;
    assign bad      = 1'b0;
    assign misalign = 1'b0;
`endif

    assign imem_req_valid = req_ok && !redirect_valid;
    assign imem_req_addr  = next_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // Ignore responses with nothing outstanding (e.g. left over from before a reset).
    assign rsp_take       = imem_rsp_valid && (out_cnt != '0);
    assign rsp_keep       = rsp_take && (drop_cnt == '0) && (state == RUN);
    assign pop            = instr_valid && instr_ready && !redirect_valid;

    // Kept requests since the last redirect are contiguous, so the oldest one sits
    // (out_cnt - drop_cnt) words behind next_pc.
    assign pend   = 32'(out_cnt - drop_cnt);
    assign rsp_pc = next_pc - (pend << 2);

    assign instr_valid = (occ != '0);
    assign instr       = ins_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];

    always_comb begin
        state_n   = state;
        next_pc_n = next_pc;
        out_n     = out_cnt;
        drop_n    = drop_cnt;
        occ_n     = occ;
        rd_n      = rd_ptr;
        wr_n      = wr_ptr;
        if (req_fire) begin
            next_pc_n = next_pc + 32'd4;
            out_n     = out_n + CW'(1);
        end
        if (rsp_take) begin
            out_n = out_n - CW'(1);
            if (drop_cnt != '0)
                drop_n = drop_cnt - CW'(1);
        end
        if (rsp_keep) begin
            wr_n  = wr_ptr + PW'(1);
            occ_n = occ_n + CW'(1);
        end
        if (pop) begin
            rd_n  = rd_ptr + PW'(1);
            occ_n = occ_n - CW'(1);
        end
        if (redirect_valid) begin
            occ_n     = '0;
            rd_n      = '0;
            wr_n      = '0;
            drop_n    = out_n;
            next_pc_n = tgt;
            if (bad)
                state_n = HALT;
        end
        req_ok_n = (state_n == RUN) && (({1'b0, occ_n} + {1'b0, out_n}) < CREDIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            next_pc  <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            occ      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            req_ok   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]  <= '0;
                ins_mem[i] <= '0;
            end
        end else begin
            state    <= state_n;
            next_pc  <= next_pc_n;
            out_cnt  <= out_n;
            drop_cnt <= drop_n;
            occ      <= occ_n;
            rd_ptr   <= rd_n;
            wr_ptr   <= wr_n;
            req_ok   <= req_ok_n;
            if (rsp_keep) begin
                pc_mem[wr_ptr]  <= rsp_pc;
                ins_mem[wr_ptr] <= imem_rsp_data;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: memory model with random latency plus a stream-level reference.
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instr, instr_pc;
    logic        misalign;

    instr_fetch #(.RESET_PC(RST_PC), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; int due; int tag;} mreq_t;
    mreq_t       mq[$];
    logic [31:0] reqlog[$];
    int          errors = 0, checks = 0, cyc = 0;
    int          epoch, buffered, nreq, npop;
    int          rdy_pct = 100, irdy_pct = 100, rsp_pct = 100, lat_min = 1, lat_max = 1;
    logic [31:0] exp_req, exp_pc, last_pop_pc;
    bit          live, running, exp_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit roll(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    task automatic model_reset();
        mq.delete();
        epoch = 0; buffered = 0;
        exp_req = RST_PC; exp_pc = RST_PC;
        live = 0; running = 1; exp_mis = 0;
    endtask

    // Asserted mid-cycle; returns at a falling edge with rst_n released.
    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        check("rst_instr_valid", instr_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_misalign", misalign, 0);
        model_reset();
        imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input bit rdr, input logic [31:0] rpc);
        mreq_t r;
        bit    rdy, irdy;
        logic [31:0] tgt;
        rdy  = roll(rdy_pct);
        irdy = roll(irdy_pct);
        imem_req_ready = rdy; instr_ready = irdy;
        redirect_valid = rdr; redirect_pc = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc && roll(rsp_pct)) begin
            imem_rsp_valid = 1'b1; imem_rsp_data = word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
        end
        #1;
        check("instr_valid", instr_valid, buffered > 0);
        check("req_valid", imem_req_valid, live && running && !rdr && (mq.size() + buffered < D));
        check("misalign", misalign, exp_mis);
        if (imem_rsp_valid) begin
            r = mq.pop_front();
            if (running && r.tag == epoch) buffered++;
        end
        if (imem_req_valid && rdy) begin
            check("req_addr", imem_req_addr, exp_req);
            reqlog.push_back(imem_req_addr);
            mq.push_back('{addr: imem_req_addr, due: cyc + $urandom_range(lat_min, lat_max), tag: epoch});
            exp_req += 4;
            nreq++;
        end
        if (instr_valid && irdy && !rdr) begin
            check("instr_pc", instr_pc, exp_pc);
            check("instr", instr, word(exp_pc));
            last_pop_pc = instr_pc;
            exp_pc += 4;
            buffered--;
            npop++;
        end
        if (rdr) begin
`ifdef IF_MISALIGN_CHECK_EN
            tgt = rpc;
            if (rpc[1:0] != 2'b00) begin running = 0; exp_mis = 1; end
`else
            tgt = rpc & 32'hFFFF_FFFC;
`endif
            epoch++; buffered = 0;
            exp_req = tgt; exp_pc = tgt;
        end
        @(posedge clk);
        cyc++;
        if (rst_n) live = 1;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0);
    endtask

    initial begin
        int n0, k;
        model_reset();
        @(negedge clk);
        do_reset();

        // Straight-line fetch with a 1-cycle memory
        reqlog.delete();
        run(12);
        check("seq_a0", reqlog[0], 32'h0);
        check("seq_a1", reqlog[1], 32'h4);
        check("seq_a2", reqlog[2], 32'h8);

        // Downstream stall: exactly DEPTH fetches, nothing lost afterwards
        do_reset();
        irdy_pct = 0; nreq = 0; npop = 0;
        run(10);
        check("stall_reqs", nreq, D);
        irdy_pct = 100;
        run(8);
        check("stall_drain", npop >= D, 1);

        // Redirect with two requests outstanding
        do_reset();
        lat_min = 3; lat_max = 3;
        k = 0;
        while (mq.size() < 2 && k < 10) begin cycle(1'b0, '0); k++; end
        check("outstanding2", mq.size(), 2);
        cycle(1'b1, 32'h100);
        n0 = npop; k = 0;
        while (npop == n0 && k < 20) begin cycle(1'b0, '0); k++; end
        check("redir_first_pc", last_pop_pc, 32'h100);
        lat_min = 1; lat_max = 1;

        // Address wrap
        run(3);
        cycle(1'b1, 32'hFFFF_FFF8);
        reqlog.delete(); k = 0;
        while (reqlog.size() < 3 && k < 20) begin cycle(1'b0, '0); k++; end
        check("wrap_cnt", reqlog.size(), 3);
        check("wrap_a2", reqlog[2], 32'h0);

        // Misaligned redirect
        run(3);
        cycle(1'b1, 32'h102);
        reqlog.delete(); n0 = nreq;
`ifdef IF_MISALIGN_CHECK_EN
        run(6);
        check("halt_misalign", misalign, 1);
        check("halt_noreq", nreq - n0, 0);
        do_reset();
`else
        k = 0;
        while (reqlog.size() < 1 && k < 20) begin cycle(1'b0, '0); k++; end
        check("align_req", reqlog.size() > 0 ? reqlog[0] : 32'hDEAD_BEEF, 32'h100);
`endif

        // Random traffic with occasional redirects and variable latency
        rdy_pct = 70; irdy_pct = 60; rsp_pct = 80; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            rpc = {$urandom_range(0, 255), 2'b00} + 32'h0000_1000;
`ifndef IF_MISALIGN_CHECK_EN
            rpc[1:0] = 2'($urandom);
`endif
            cycle(roll(4), rpc);
        end

        // Reset mid-burst, then restart from RESET_PC
        rdy_pct = 100; irdy_pct = 100;
        run(5);
        do_reset();
        reqlog.delete(); k = 0;
        while (reqlog.size() < 1 && k < 10) begin cycle(1'b0, '0); k++; end
        check("post_rst_req", reqlog.size() > 0 ? reqlog[0] : 32'hDEAD_BEEF, RST_PC);
        run(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
